parity_serial_tx: RTL and testbench
===================================

Name: parity_serial_tx

Overview:
Serial transmitter that emits an N-bit word as a framed bit stream with an appended parity bit. It is the transmitting end of the team's registered parity-checking path: it takes a parallel word over a valid/ready handshake and shifts it out LSB first. The frame is start bit, data bits, parity, stop bit. The receiving side recovers the word and checks its parity.

Parameters:
N, 4, data word width in bits (N >= 1)
ODD_PARITY, 0, 0 = even parity (total ones in data+parity is even); 1 = odd parity
CLKS_PER_BIT, 4, clock cycles each serial bit is held on tx_out (>= 1)

Ports:
clk  input  1  clock; all state updates on posedge
reset  input  1  synchronous, active-low reset
in_data  input  N  parallel word to transmit
in_valid  input  1  in_data is valid
in_ready  output  1  block can accept a word; combinational, high only in IDLE
tx_out  output  1  serial line, registered, idles high
busy  output  1  registered, high from the cycle after accept through the last stop-bit cycle
parity_out  output  1  registered parity bit of the last accepted word

Behaviour:
- Reset (reset==0 at posedge): state=IDLE, tx_out=1, busy=0, parity_out=0, bit and cycle counters=0. Reset takes priority over everything.
- Reset mid-frame aborts the frame: tx_out=1 from the next cycle, the word is discarded and no stop bit is sent.
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - tx_out=1 and in_ready=1.
  - Accept happens at a posedge with in_valid && in_ready.
  - On accept: latch in_data into the shift register and latch the parity into parity_out. Parity = XOR of in_data, XOR ODD_PARITY.
  - Next state is START; busy=1 from the next cycle.
- START: tx_out=0 for CLKS_PER_BIT cycles, then DATA.
- DATA:
  - tx_out = latched bit i for CLKS_PER_BIT cycles each, i = 0..N-1, LSB first.
  - The bit counter wraps to 0 after bit N-1, then state goes to PARITY.
- PARITY: tx_out=parity_out for CLKS_PER_BIT cycles, then STOP.
- STOP: tx_out=1 for CLKS_PER_BIT cycles, then IDLE; busy=0 in that IDLE cycle.
- Latency: the first start-bit cycle appears on tx_out in the cycle after the accepting edge.
- Frame length is (N+3)*CLKS_PER_BIT cycles.
- Minimum frame-to-frame period is (N+3)*CLKS_PER_BIT+1 cycles, because IDLE always lasts at least one cycle.
- The cycle counter counts 0..CLKS_PER_BIT-1 and wraps; a state or bit advance happens on the wrap.
- Words presented while busy are ignored, not queued; in_valid may stay high and is accepted on the next IDLE cycle.
- in_data changes after accept do not affect the frame in flight.
- parity_out holds its value until the next accept.
- Counter widths are $clog2 of their ranges, minimum 1 bit.

Test Plan:
- Reset: hold reset=0 for 2 cycles with in_valid=1 -> tx_out=1, busy=0, in_ready=1 after release, no frame started during reset.
- Basic even frame (N=4, CLKS_PER_BIT=4, ODD_PARITY=0): in_data=4'b1011, pulse in_valid 1 cycle -> parity_out=1. tx_out per 4-cycle slot is 0,1,1,0,1,1,1. busy high for 28 cycles, in_ready low during them.
- Zero word, both parities: in_data=4'b0000 -> parity bit 0 with ODD_PARITY=0, 1 with ODD_PARITY=1. Data slots are all 0.
- Back-to-back: in_valid held high with 4'b0110, then 4'b1111 -> second start bit begins exactly 29 cycles after the first. Both parity bits are 0 (even).
- Busy ignore: change in_data to 4'b0001 and pulse in_valid mid-frame -> the frame in flight is unchanged and no extra frame is sent.
- Reset mid-frame: assert reset during DATA bit 2 -> tx_out=1 next cycle, state IDLE. A new word, 4'b1000, then transmits correctly with parity 1.

Source files
------------

// File: rtl/parity_serial_tx.sv
// parity_serial_tx: accepts an N-bit word over a valid/ready handshake and
// sends it LSB first as a framed serial stream: start bit (0), N data bits,
// parity bit, stop bit (1). Every serial bit is held for CLKS_PER_BIT clocks.
// The line idles high, and a synchronous active-low reset aborts a frame.
module parity_serial_tx #(
  parameter int N            = 4,
  parameter bit ODD_PARITY   = 1'b0,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] in_data,
  input  logic         in_valid,
  output logic         in_ready,
  output logic         tx_out,
  output logic         busy,
  output logic         parity_out
);

  // The counters are never narrower than one bit, so N=1 and CLKS_PER_BIT=1
  // still get legal vectors.
  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] CYC_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(N - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t        state_reg, state_next;
  logic [CW-1:0] cyc_reg, cyc_next;
  logic [BW-1:0] bit_reg, bit_next;
  logic [N-1:0]  shift_reg, shift_next;
  logic          tx_reg, tx_next;
  logic          busy_reg, busy_next;
  logic          parity_reg, parity_next;
  logic          accept;
  logic          slot_done;

  // The block is ready only in IDLE. A word offered while a frame is in
  // flight is not queued. It is taken on the next IDLE cycle if in_valid is
  // still high.
  assign in_ready  = (state_reg == IDLE);
  assign accept    = in_valid && in_ready;
  assign slot_done = (cyc_reg == CYC_LAST);

  assign tx_out     = tx_reg;
  assign busy       = busy_reg;
  assign parity_out = parity_reg;

  // Next-state logic. tx_next is the line level for the next state, so the
  // registered tx_out always matches the state it is in. The first start-bit
  // cycle therefore appears right after the accepting edge.
  always_comb begin
    state_next  = state_reg;
    cyc_next    = cyc_reg;
    bit_next    = bit_reg;
    shift_next  = shift_reg;
    tx_next     = tx_reg;
    parity_next = parity_reg;

    case (state_reg)
      IDLE: begin
        tx_next  = 1'b1;
        cyc_next = '0;
        bit_next = '0;
        if (accept) begin
          shift_next  = in_data;
          parity_next = (^in_data) ^ ODD_PARITY;
          state_next  = START;
          tx_next     = 1'b0;
        end
      end

      START: begin
        if (slot_done) begin
          cyc_next   = '0;
          state_next = DATA;
          tx_next    = shift_reg[0];
        end else begin
          cyc_next = cyc_reg + 1'b1;
        end
      end

      DATA: begin
        if (slot_done) begin
          cyc_next = '0;
          if (bit_reg == BIT_LAST) begin
            bit_next   = '0;
            state_next = PARITY;
            tx_next    = parity_reg;
          end else begin
            // Shift toward bit 0 so the next data bit is always at the LSB.
            bit_next   = bit_reg + 1'b1;
            shift_next = shift_reg >> 1;
            tx_next    = shift_next[0];
          end
        end else begin
          cyc_next = cyc_reg + 1'b1;
        end
      end

      PARITY: begin
        if (slot_done) begin
          cyc_next   = '0;
          state_next = STOP;
          tx_next    = 1'b1;
        end else begin
          cyc_next = cyc_reg + 1'b1;
        end
      end

      STOP: begin
        if (slot_done) begin
          cyc_next   = '0;
          state_next = IDLE;
          tx_next    = 1'b1;
        end else begin
          cyc_next = cyc_reg + 1'b1;
        end
      end

      default: begin
        state_next = IDLE;
        cyc_next   = '0;
        bit_next   = '0;
        tx_next    = 1'b1;
      end
    endcase

    // busy tracks the next state, so it goes high the cycle after accept and
    // goes low in the IDLE cycle that follows the stop bit.
    busy_next = (state_next != IDLE);
  end

  // State and datapath registers. Reset wins over everything and discards any
  // frame in flight.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg  <= IDLE;
      cyc_reg    <= '0;
      bit_reg    <= '0;
      shift_reg  <= '0;
      tx_reg     <= 1'b1;
      busy_reg   <= 1'b0;
      parity_reg <= 1'b0;
    end else begin
      state_reg  <= state_next;
      cyc_reg    <= cyc_next;
      bit_reg    <= bit_next;
      shift_reg  <= shift_next;
      tx_reg     <= tx_next;
      busy_reg   <= busy_next;
      parity_reg <= parity_next;
    end
  end

endmodule

// File: tb/tb_parity_serial_tx.sv
// Bench for parity_serial_tx. It drives an even-parity instance and an
// odd-parity instance. A negedge monitor pushes the expected word and parity
// onto a scoreboard at every accept. Each test captures whole frames from the
// serial line, pops the scoreboard and compares.
module tb_parity_serial_tx;
  localparam int N           = 4;
  localparam int CPB         = 4;
  localparam int SLOTS       = N + 3;
  localparam int FRAME_LEN   = SLOTS * CPB;
  localparam int WAIT_BUDGET = 100;

  logic         clk        = 1'b0;
  logic         reset      = 1'b0;
  logic [N-1:0] in_data    = '0;
  logic         in_valid   = 1'b0;
  logic         in_ready, tx_out, busy, parity_out;
  logic [N-1:0] data_odd   = '0;
  logic         valid_odd  = 1'b0;
  logic         ready_odd, tx_odd, busy_odd, parity_odd;

  typedef struct {
    logic [N-1:0] data;
    logic         par;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   cyc      = 0;
  int   acc_cyc  = 0;
  int   acc_cnt  = 0;
  int   n_checks = 0;
  int   n_fail   = 0;

  parity_serial_tx #(.N(N), .ODD_PARITY(1'b0), .CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .tx_out(tx_out), .busy(busy), .parity_out(parity_out)
  );

  parity_serial_tx #(.N(N), .ODD_PARITY(1'b1), .CLKS_PER_BIT(CPB)) dut_odd (
    .clk(clk), .reset(reset), .in_data(data_odd), .in_valid(valid_odd),
    .in_ready(ready_odd), .tx_out(tx_odd), .busy(busy_odd), .parity_out(parity_odd)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Record each accept and push the word and parity expected for it.
  always @(negedge clk) begin
    if (reset === 1'b1) begin
      if (in_valid === 1'b1 && in_ready === 1'b1) begin
        mon_e.data = in_data;
        mon_e.par  = ^in_data;
        sb_q.push_back(mon_e);
        acc_cyc = cyc;
        acc_cnt++;
      end
      if (valid_odd === 1'b1 && ready_odd === 1'b1) begin
        mon_e.data = data_odd;
        mon_e.par  = ~(^data_odd);
        sb_q.push_back(mon_e);
        acc_cyc = cyc;
        acc_cnt++;
      end
    end
  end

  // Offer a word for one cycle. On return the bench is in the cycle after the
  // accepting edge, before its negedge.
  task automatic send_word(input bit sel, input logic [N-1:0] d);
    @(posedge clk); #2;
    if (sel) begin data_odd = d; valid_odd = 1'b1; end
    else     begin in_data  = d; in_valid  = 1'b1; end
    @(posedge clk); #2;
    valid_odd = 1'b0;
    in_valid  = 1'b0;
  endtask

  // Wait for a start bit, then record one sample per cycle for a whole frame.
  // The first sample of each slot is that slot's value, and the remaining
  // samples in the slot must match it. Returns at the negedge of the cycle
  // after the frame.
  task capture_frame(input bit sel, output bit found, output int start_cyc,
                     output logic [SLOTS-1:0] slots, output bit stable,
                     output int busy_cnt, output int low_rdy_cnt, output bit idle_after);
    logic t, b, r;
    found = 1'b0; start_cyc = 0; slots = '0; stable = 1'b1;
    busy_cnt = 0; low_rdy_cnt = 0; idle_after = 1'b0;
    for (int i = 0; i < WAIT_BUDGET; i++) begin
      @(negedge clk);
      t = sel ? tx_odd : tx_out;
      if (t === 1'b0) begin
        found = 1'b1;
        break;
      end
    end
    if (found) begin
      start_cyc = cyc;
      for (int k = 0; k < FRAME_LEN; k++) begin
        if (k != 0) @(negedge clk);
        t = sel ? tx_odd : tx_out;
        b = sel ? busy_odd : busy;
        r = sel ? ready_odd : in_ready;
        if (k % CPB == 0) slots[k / CPB] = t;
        else if (t !== slots[k / CPB]) stable = 1'b0;
        if (b === 1'b1) busy_cnt++;
        if (r === 1'b0) low_rdy_cnt++;
      end
      @(negedge clk);
      t = sel ? tx_odd : tx_out;
      b = sel ? busy_odd : busy;
      r = sel ? ready_odd : in_ready;
      idle_after = (t === 1'b1) && (b === 1'b0) && (r === 1'b1);
    end
  endtask

  task test_reset();
    int bad;
    reset = 1'b0; in_valid = 1'b1; in_data = 4'b1011;
    @(posedge clk); @(posedge clk); @(negedge clk);
    n_checks++; if (tx_out !== 1'b1) begin n_fail++; $display("FAIL reset_tx: got %b expected 1", tx_out); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_checks++; if (parity_out !== 1'b0) begin n_fail++; $display("FAIL reset_parity: got %b expected 0", parity_out); end
    @(posedge clk); #2;
    in_valid = 1'b0; reset = 1'b1;
    @(negedge clk);
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b expected 1", in_ready); end
    bad = 0;
    repeat (10) begin
      @(negedge clk);
      if (tx_out !== 1'b1 || busy !== 1'b0 || tx_odd !== 1'b1) bad++;
    end
    n_checks++; if (bad != 0 || acc_cnt != 0) begin n_fail++; $display("FAIL reset_no_frame: got %0d bad cycles, %0d accepts expected 0, 0", bad, acc_cnt); end
  endtask

  task test_basic_even();
    exp_t e; bit found, stable, idle_after; int sc, bc, rc; logic [SLOTS-1:0] sl;
    send_word(1'b0, 4'b1011);
    n_checks++; if (parity_out !== 1'b1) begin n_fail++; $display("FAIL basic_parity_out: got %b expected 1", parity_out); end
    capture_frame(1'b0, found, sc, sl, stable, bc, rc, idle_after);
    n_checks++; if (!found) begin n_fail++; $display("FAIL basic_found: got no start bit expected one"); end
    n_checks++; if (sc != acc_cyc + 1) begin n_fail++; $display("FAIL basic_latency: got start at %0d expected %0d", sc, acc_cyc + 1); end
    n_checks++;
    if (sb_q.size() == 0) begin n_fail++; $display("FAIL basic_sb: got empty scoreboard expected one entry"); end
    else begin
      e = sb_q.pop_front();
      if (sl !== {1'b1, e.par, e.data, 1'b0}) begin n_fail++; $display("FAIL basic_slots: got %b expected %b", sl, {1'b1, e.par, e.data, 1'b0}); end
    end
    n_checks++;
    if (!(stable && bc == FRAME_LEN && rc == FRAME_LEN && idle_after)) begin
      n_fail++; $display("FAIL basic_shape: got stable=%0b busy=%0d ready_low=%0d idle=%0b expected 1 %0d %0d 1", stable, bc, rc, idle_after, FRAME_LEN, FRAME_LEN);
    end
  endtask

  task test_zero_word();
    exp_t e; bit found, stable, idle_after; int sc, bc, rc; logic [SLOTS-1:0] sl;
    for (int s = 0; s < 2; s++) begin
      send_word(s[0], 4'b0000);
      n_checks++;
      if ((s == 0 ? parity_out : parity_odd) !== s[0]) begin
        n_fail++; $display("FAIL zero_parity_out[%0d]: got %b expected %b", s, (s == 0 ? parity_out : parity_odd), s[0]);
      end
      capture_frame(s[0], found, sc, sl, stable, bc, rc, idle_after);
      n_checks++;
      if (sb_q.size() == 0) begin n_fail++; $display("FAIL zero_sb[%0d]: got empty scoreboard expected one entry", s); end
      else begin
        e = sb_q.pop_front();
        if (!found || sl !== {1'b1, e.par, e.data, 1'b0}) begin
          n_fail++; $display("FAIL zero_slots[%0d]: got found=%0b %b expected %b", s, found, sl, {1'b1, e.par, e.data, 1'b0});
        end
      end
      n_checks++;
      if (!(stable && bc == FRAME_LEN && rc == FRAME_LEN && idle_after)) begin
        n_fail++; $display("FAIL zero_shape[%0d]: got stable=%0b busy=%0d ready_low=%0d idle=%0b", s, stable, bc, rc, idle_after);
      end
    end
  endtask

  task test_back_to_back();
    exp_t e; bit found, stable, idle_after; int s1, s2, bc, rc, acc0; logic [SLOTS-1:0] sl;
    acc0 = acc_cnt;
    @(posedge clk); #2;
    in_data = 4'b0110; in_valid = 1'b1;
    @(posedge clk); #2;
    in_data = 4'b1111;
    for (int f = 0; f < 2; f++) begin
      capture_frame(1'b0, found, s1, sl, stable, bc, rc, idle_after);
      if (f == 0) begin
        s2 = s1;
        @(posedge clk); #2;
        in_valid = 1'b0;
      end
      n_checks++; if (parity_out !== 1'b0) begin n_fail++; $display("FAIL b2b_parity_out[%0d]: got %b expected 0", f, parity_out); end
      n_checks++;
      if (sb_q.size() == 0) begin n_fail++; $display("FAIL b2b_sb[%0d]: got empty scoreboard expected one entry", f); end
      else begin
        e = sb_q.pop_front();
        if (!found || sl !== {1'b1, e.par, e.data, 1'b0}) begin
          n_fail++; $display("FAIL b2b_slots[%0d]: got found=%0b %b expected %b", f, found, sl, {1'b1, e.par, e.data, 1'b0});
        end
      end
      n_checks++;
      if (!(stable && bc == FRAME_LEN && rc == FRAME_LEN && idle_after)) begin
        n_fail++; $display("FAIL b2b_shape[%0d]: got stable=%0b busy=%0d ready_low=%0d idle=%0b", f, stable, bc, rc, idle_after);
      end
    end
    n_checks++; if (s1 - s2 != FRAME_LEN + 1) begin n_fail++; $display("FAIL b2b_period: got %0d expected %0d", s1 - s2, FRAME_LEN + 1); end
    @(posedge clk); #3;
    n_checks++; if (acc_cnt - acc0 != 2) begin n_fail++; $display("FAIL b2b_accepts: got %0d expected 2", acc_cnt - acc0); end
  endtask

  task test_busy_ignore();
    exp_t e; bit found, stable, idle_after; int sc, bc, rc, bad; logic [SLOTS-1:0] sl;
    send_word(1'b0, 4'b0110);
    fork
      capture_frame(1'b0, found, sc, sl, stable, bc, rc, idle_after);
      begin
        repeat (10) @(posedge clk);
        #2; in_data = 4'b0001; in_valid = 1'b1;
        @(posedge clk); #2; in_valid = 1'b0;
      end
    join
    n_checks++;
    if (sb_q.size() != 1) begin n_fail++; $display("FAIL busy_sb_size: got %0d expected 1", sb_q.size()); end
    if (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      n_checks++;
      if (!found || sl !== {1'b1, e.par, e.data, 1'b0} || e.data !== 4'b0110) begin
        n_fail++; $display("FAIL busy_slots: got found=%0b %b data %b expected %b data 0110", found, sl, e.data, {1'b1, e.par, e.data, 1'b0});
      end
    end
    n_checks++;
    if (!(stable && bc == FRAME_LEN && rc == FRAME_LEN && idle_after)) begin
      n_fail++; $display("FAIL busy_shape: got stable=%0b busy=%0d ready_low=%0d idle=%0b", stable, bc, rc, idle_after);
    end
    bad = 0;
    repeat (40) begin
      @(negedge clk);
      if (tx_out !== 1'b1 || busy !== 1'b0) bad++;
    end
    n_checks++; if (bad != 0 || sb_q.size() != 0) begin n_fail++; $display("FAIL busy_extra_frame: got %0d active cycles, %0d queued expected 0, 0", bad, sb_q.size()); end
    n_checks++; if (parity_out !== 1'b0) begin n_fail++; $display("FAIL busy_parity_hold: got %b expected 0", parity_out); end
  endtask

  task test_reset_mid_frame();
    exp_t e; bit found, stable, idle_after; int sc, bc, rc, bad; logic [SLOTS-1:0] sl;
    send_word(1'b0, 4'b1011);
    repeat (13) @(posedge clk);
    #2; reset = 1'b0;
    @(negedge clk);
    n_checks++; if (tx_out !== 1'b0) begin n_fail++; $display("FAIL mid_bit2: got %b expected 0", tx_out); end
    @(posedge clk); #2; reset = 1'b1;
    @(negedge clk);
    n_checks++;
    if (tx_out !== 1'b1 || busy !== 1'b0 || in_ready !== 1'b1 || parity_out !== 1'b0) begin
      n_fail++; $display("FAIL mid_abort: got tx=%b busy=%b ready=%b par=%b expected 1 0 1 0", tx_out, busy, in_ready, parity_out);
    end
    n_checks++;
    if (sb_q.size() != 1) begin n_fail++; $display("FAIL mid_sb_size: got %0d expected 1", sb_q.size()); end
    while (sb_q.size() != 0) e = sb_q.pop_front();
    bad = 0;
    repeat (40) begin
      @(negedge clk);
      if (tx_out !== 1'b1 || busy !== 1'b0) bad++;
    end
    n_checks++; if (bad != 0) begin n_fail++; $display("FAIL mid_no_stop: got %0d active cycles expected 0", bad); end
    send_word(1'b0, 4'b1000);
    n_checks++; if (parity_out !== 1'b1) begin n_fail++; $display("FAIL mid_new_parity: got %b expected 1", parity_out); end
    capture_frame(1'b0, found, sc, sl, stable, bc, rc, idle_after);
    n_checks++;
    if (sb_q.size() == 0) begin n_fail++; $display("FAIL mid_new_sb: got empty scoreboard expected one entry"); end
    else begin
      e = sb_q.pop_front();
      if (!found || sl !== {1'b1, e.par, e.data, 1'b0}) begin
        n_fail++; $display("FAIL mid_new_slots: got found=%0b %b expected %b", found, sl, {1'b1, e.par, e.data, 1'b0});
      end
    end
    n_checks++;
    if (!(stable && bc == FRAME_LEN && rc == FRAME_LEN && idle_after)) begin
      n_fail++; $display("FAIL mid_new_shape: got stable=%0b busy=%0d ready_low=%0d idle=%0b", stable, bc, rc, idle_after);
    end
  endtask

  task test_random_words();
    exp_t e; bit found, stable, idle_after; int sc, bc, rc; logic [SLOTS-1:0] sl; logic [N-1:0] d;
    for (int i = 0; i < 4; i++) begin
      d = N'($urandom_range(0, (1 << N) - 1));
      send_word(1'b0, d);
      n_checks++; if (parity_out !== ^d) begin n_fail++; $display("FAIL rand_parity[%0d]: got %b expected %b", i, parity_out, ^d); end
      capture_frame(1'b0, found, sc, sl, stable, bc, rc, idle_after);
      n_checks++;
      if (sb_q.size() == 0) begin n_fail++; $display("FAIL rand_sb[%0d]: got empty scoreboard expected one entry", i); end
      else begin
        e = sb_q.pop_front();
        if (!found || !stable || sl !== {1'b1, e.par, e.data, 1'b0}) begin
          n_fail++; $display("FAIL rand_slots[%0d]: got found=%0b stable=%0b %b expected %b", i, found, stable, sl, {1'b1, e.par, e.data, 1'b0});
        end
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected one by 200000");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_basic_even();
    test_zero_word();
    test_back_to_back();
    test_busy_ignore();
    test_reset_mid_frame();
    test_random_words();
    @(posedge clk); #3;
    n_checks++; if (sb_q.size() != 0) begin n_fail++; $display("FAIL final_sb_empty: got %0d expected 0", sb_q.size()); end
    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule
